// File: rtl/adc_average_multi_if.sv
// Stream-side bundle for the multi-channel ADC averager: control, sample input and averaged output.
interface adc_average_multi_if #(
  parameter int ADC_WIDTH = 12,
  parameter int N_CH      = 2,
  parameter int LW        = 4
);
  logic                      EN;
  logic [LW-1:0]             LOG2_LEN;
  logic                      IN_VALID;
  logic [N_CH*ADC_WIDTH-1:0] DATA_IN;
  logic                      OUT_VALID;
  logic [N_CH*ADC_WIDTH-1:0] DATA_OUT;
  logic                      BUSY;

  modport master (
    output EN, LOG2_LEN, IN_VALID, DATA_IN,
    input  OUT_VALID, DATA_OUT, BUSY
  );

  modport slave (
    input  EN, LOG2_LEN, IN_VALID, DATA_IN,
    output OUT_VALID, DATA_OUT, BUSY
  );
endinterface

// File: rtl/adc_average_multi.sv
// Boxcar averager over 2^L valid samples per channel; strobe one cycle after the closing sample, no backpressure.
// Define ADC_AVG_ROUND_EN for round-half-up of the average instead of truncation toward -inf.
module adc_average_multi #(
  parameter int ADC_WIDTH = 12,
  parameter int N_CH      = 2,
  parameter int MAX_LOG2  = 10,
  parameter int LW        = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  adc_average_multi_if.slave   bus
);
  localparam int AW = ADC_WIDTH + MAX_LOG2;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic signed [AW-1:0]      acc_q [N_CH];
  logic signed [AW-1:0]      acc_d [N_CH];
  logic signed [AW-1:0]      smp_ext [N_CH];
  logic signed [AW-1:0]      sum [N_CH];
  logic [MAX_LOG2-1:0]       cnt_q, cnt_d, cnt_max;
  logic [LW-1:0]             l_q, l_d, l_clamp;
  logic                      out_valid_q, out_valid_d;
  logic [N_CH*ADC_WIDTH-1:0] data_out_q, data_out_d;
  logic                      closing;
`ifdef ADC_AVG_ROUND_EN
  logic signed [AW-1:0]      rnd;
`endif

  assign l_clamp = (bus.LOG2_LEN > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : bus.LOG2_LEN;

  // Last counter value of the window: 2^L-1, i.e. the low L bits set.
  always_comb begin
    cnt_max = '0;
    for (int i = 0; i < MAX_LOG2; i++) cnt_max[i] = (i < int'(l_q));
  end

`ifdef ADC_AVG_ROUND_EN
  always_comb begin
    rnd = '0;
    for (int i = 0; i < AW; i++) rnd[i] = (i + 1 == int'(l_q));
  end
`endif

  assign closing = (state_q == ACC) && bus.EN && bus.IN_VALID && (cnt_q == cnt_max);

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      smp_ext[k] = {{MAX_LOG2{bus.DATA_IN[k*ADC_WIDTH + ADC_WIDTH - 1]}},
                    bus.DATA_IN[k*ADC_WIDTH +: ADC_WIDTH]};
`ifdef ADC_AVG_ROUND_EN
      sum[k] = acc_q[k] + smp_ext[k] + rnd;
`else
      sum[k] = acc_q[k] + smp_ext[k];
`endif
    end
  end

  // State register and datapath flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= acc_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.EN)  state_d = ACC;
      ACC:     if (!bus.EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    l_d         = l_q;
    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    for (int k = 0; k < N_CH; k++) acc_d[k] = acc_q[k];

    if (state_q == IDLE || !bus.EN) begin
      // Idle or aborted window: partial sums are discarded, DATA_OUT is kept.
      cnt_d = '0;
      for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
      if (state_q == IDLE && bus.EN) l_d = l_clamp;
    end else if (bus.IN_VALID) begin
      if (closing) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        l_d         = l_clamp;
        for (int k = 0; k < N_CH; k++) begin
          data_out_d[k*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(sum[k] >>> l_q);
          acc_d[k] = '0;
        end
      end else begin
        cnt_d = cnt_q + MAX_LOG2'(1);
        for (int k = 0; k < N_CH; k++) acc_d[k] = acc_q[k] + smp_ext[k];
      end
    end
  end

  always_comb begin
    bus.BUSY      = (state_q == ACC);
    bus.OUT_VALID = out_valid_q;
    bus.DATA_OUT  = data_out_q;
  end
endmodule
